fsm_engine_arbiter: RTL and testbench
=====================================

Name: fsm_engine_arbiter

Overview:
- Shares one fsm_dut processing engine between NUM_REQ requesters.
- Arbitrates requests round-robin, then runs the engine's start/release handshake.
- Collects the engine's result and returns it on one response channel, tagged with the requester id.
- A per-phase timeout watchdog aborts hung transactions and reports an error.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 8: data width, equal to the engine's DATA_WIDTH.
- TIMEOUT, 16: maximum cycles allowed in RUN or COLLECT before abort, ≥8.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester operand; slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot accept
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  clog2(NUM_REQ)  requester that owns the result
- resp_data  out  DATA_WIDTH  engine result
- resp_error  out  1  transaction aborted
- eng_enable  out  1  to engine enable
- eng_input_signal  out  2  to engine input_signal
- eng_data_in  out  DATA_WIDTH  to engine data_in
- eng_state  in  2  engine current_state
- eng_busy  in  1  engine busy
- eng_done  in  1  engine done
- eng_valid  in  1  engine valid_out
- eng_data_out  in  DATA_WIDTH  engine data_out
- active  out  1  transaction in flight (state ≠ IDLE)
- abort_count  out  8  saturating abort counter

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0, eng_input_signal=00, abort_count=0.
  - Reset mid-transaction discards it; no response is issued.
- Controller states: IDLE, START, RUN, RELEASE, COLLECT, RESP, ABORT.
- Engine drive outside START/RELEASE/ABORT: eng_enable=0, eng_input_signal=00.
- IDLE:
  - Accepts only when eng_state=00, eng_busy=0 and some req_valid=1.
  - Winner = first asserted index searching from pointer+1 modulo NUM_REQ.
  - req_ready[winner]=1 combinationally that cycle; all other bits 0.
  - On accept: latch id and data, pointer←winner, go to START.
  - req_ready is 0 in every other state.
- START (1 cycle): eng_enable=1, eng_input_signal=01, eng_data_in=latched data → RUN, timeout counter cleared.
- RUN:
  - eng_state=10 (WAIT) → RELEASE.
  - Otherwise counter++; at TIMEOUT cycles → ABORT.
- RELEASE (1 cycle): eng_input_signal=10 → COLLECT, counter cleared.
- COLLECT:
  - eng_valid=1 and eng_done=1 → capture eng_data_out into resp_data, resp_error=0 → RESP.
  - Otherwise counter++; at TIMEOUT → ABORT.
- ABORT (1 cycle):
  - eng_input_signal=11 (returns an engine in WAIT to IDLE).
  - resp_data=0, resp_error=1, abort_count+1 saturating at 255 → RESP.
- RESP:
  - resp_valid=1; resp_id/resp_data/resp_error stable until resp_valid&&resp_ready.
  - On handshake: resp_valid=0 next cycle → IDLE.
  - No new accept may occur in the handshake cycle.
- Latency with a conforming engine:
  - Accept at cycle t; engine in PROCESS t+2..t+5, WAIT seen t+6.
  - RELEASE t+7; engine valid/done at t+9; resp_valid first high at t+10.
- Throughput: one transaction in flight at a time; back-to-back accept no earlier than the cycle after the response handshake.
- A requester deasserting req_valid before accept loses nothing; requests are not queued internally.

Test Plan:
- Single request, req 2 data 0x10 → req_ready[2] in accept cycle; resp_valid at t+10 with resp_id=2, resp_data=0xDD, resp_error=0.
- All four req_valid held high for 4 transactions, resp_ready=1 → grant order 0,1,2,3, then 0 again; each result correct for its operand.
- Req 1 and req 3 pending after grant to 1 → next grant goes to 3, not 1.
- resp_ready held 0 for 5 cycles → resp fields stable and no new req_ready until handshake.
- Engine model stuck in PROCESS → ABORT after 16 RUN cycles; eng_input_signal=11 for 1 cycle; resp_error=1, resp_data=0; abort_count=1; next request then completes normally.
- reset_n pulsed low in RUN → all outputs 0 immediately; after release, a new request is granted to requester 0 first.

Source files
------------

// File: rtl/fsm_engine_arbiter_if.sv
// ----------------------------------------------------------------------------
// fsm_engine_arbiter_if
//
// Purpose:
//   Bundles the requester-side and response-side handshake signals of the
//   fsm_engine_arbiter. The requesters and the response consumer connect
//   through the master modport. The arbiter connects through the slave modport.
//
// Signals:
//   req_valid  [NUM_REQ]             per-requester request
//   req_data   [NUM_REQ*DATA_WIDTH]  per-requester operand, slice i = requester i
//   req_ready  [NUM_REQ]             one-hot accept from the arbiter
//   resp_valid                       result available
//   resp_ready                       consumer accepts result
//   resp_id    [clog2(NUM_REQ)]      requester that owns the result
//   resp_data  [DATA_WIDTH]          engine result (0 on abort)
//   resp_error                       transaction was aborted
// ----------------------------------------------------------------------------
interface fsm_engine_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) ();

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_error;

  // Requesters and response consumer
  modport master (
    output req_valid,
    output req_data,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_data,
    input  resp_error
  );

  // Arbiter
  modport slave (
    input  req_valid,
    input  req_data,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_data,
    output resp_error
  );

endinterface

// File: rtl/fsm_engine_arbiter.sv
// ----------------------------------------------------------------------------
// fsm_engine_arbiter
//
// Purpose:
//   Shares one fsm_dut processing engine between NUM_REQ requesters. A
//   round-robin arbiter picks one request at a time. The controller runs the
//   engine's start/release handshake and returns the result on a single
//   response channel tagged with the requester id. A per-phase watchdog aborts
//   a transaction that stalls in RUN or COLLECT for TIMEOUT cycles. An abort
//   is reported as resp_error with resp_data = 0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   bus (slave)           request/response handshake bundle
//   eng_enable            engine enable
//   eng_input_signal[2]   engine command: 01 start, 10 release, 11 abort
//   eng_data_in[DW]       operand presented to the engine during START
//   eng_state[2]          engine current state (00 IDLE, 10 WAIT)
//   eng_busy              engine busy
//   eng_done, eng_valid   engine result qualifiers
//   eng_data_out[DW]      engine result
//   active                a transaction is in flight
//   abort_count[8]        saturating count of aborted transactions
// ----------------------------------------------------------------------------
module fsm_engine_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fsm_engine_arbiter_if.slave   bus,
  output logic                  eng_enable,
  output logic [1:0]            eng_input_signal,
  output logic [DATA_WIDTH-1:0] eng_data_in,
  input  logic [1:0]            eng_state,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic                  eng_valid,
  input  logic [DATA_WIDTH-1:0] eng_data_out,
  output logic                  active,
  output logic [7:0]            abort_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] ENG_IDLE = 2'b00;
  localparam logic [1:0] ENG_WAIT = 2'b10;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_START   = 2'b01;
  localparam logic [1:0] CMD_RELEASE = 2'b10;
  localparam logic [1:0] CMD_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELEASE,
    S_COLLECT,
    S_RESP,
    S_ABORT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_error;
  logic [7:0]            r_abort_count;

  logic                  w_found;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_winner;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_eng_idle;
  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_capture;

  // Round-robin search. The walk starts one past the last winner and wraps
  // at NUM_REQ, so the most recently served requester is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Operand of the current winner. This is a plain mux keyed on the winner index.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A new request is accepted only if the engine is fully idle. A previous
  // abort or release therefore must have settled before the next start.
  assign w_eng_idle = (eng_state == ENG_IDLE) && !eng_busy;
  assign w_accept   = (r_state == S_IDLE) && w_eng_idle && w_found;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and output decode. Engine commands are pulses that last
  // exactly one cycle in START, RELEASE or ABORT. At all other times the
  // engine sees enable low and command 00.
  always_comb begin
    w_next           = r_state;
    bus.req_ready    = '0;
    eng_enable       = 1'b0;
    eng_input_signal = CMD_NONE;
    eng_data_in      = '0;
    w_cnt_clr        = 1'b0;
    w_cnt_inc        = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          bus.req_ready = NUM_REQ'(1) << w_winner;
          w_next        = S_START;
        end
      end
      S_START: begin
        eng_enable       = 1'b1;
        eng_input_signal = CMD_START;
        eng_data_in      = r_data;
        w_cnt_clr        = 1'b1;
        w_next           = S_RUN;
      end
      S_RUN: begin
        if (eng_state == ENG_WAIT) begin
          w_next = S_RELEASE;
        end else if (w_timeout) begin
          w_next = S_ABORT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        eng_enable       = 1'b1;
        eng_input_signal = CMD_RELEASE;
        w_cnt_clr        = 1'b1;
        w_next           = S_COLLECT;
      end
      S_COLLECT: begin
        if (eng_valid && eng_done) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (w_timeout) begin
          w_next = S_ABORT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ABORT: begin
        eng_enable       = 1'b1;
        eng_input_signal = CMD_ABORT;
        w_next           = S_RESP;
      end
      S_RESP: begin
        // Returning to IDLE only after the handshake keeps the handshake
        // cycle free of any new accept.
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Accept bookkeeping. The pointer reset value makes requester 0 win the
  // first arbitration after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= ID_W'(NUM_REQ - 1);
      r_id   <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_ptr  <= w_winner;
      r_id   <= w_winner;
      r_data <= w_win_data;
    end
  end

  // Watchdog counter. It is shared by RUN and COLLECT and cleared on entry to each phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response payload. It is loaded either from the engine or from the abort
  // path, and then held untouched through RESP until the handshake completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_data   <= '0;
      r_resp_error  <= 1'b0;
      r_abort_count <= '0;
    end else if (w_capture) begin
      r_resp_data  <= eng_data_out;
      r_resp_error <= 1'b0;
    end else if (r_state == S_ABORT) begin
      r_resp_data  <= '0;
      r_resp_error <= 1'b1;
      if (r_abort_count != 8'hFF) begin
        r_abort_count <= r_abort_count + 8'd1;
      end
    end
  end

  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_error = r_resp_error;
  assign active         = (r_state != S_IDLE);
  assign abort_count    = r_abort_count;

endmodule

// File: tb/tb_fsm_engine_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fsm_engine_arbiter
//
// Purpose:
//   Self-checking bench for fsm_engine_arbiter. A behavioural engine
//   (fsm_dut stand-in) is attached to the arbiter. Requests are randomised and
//   compared every cycle against a transaction-level reference model. The
//   model tracks the round-robin pointer, the accept cycle and the expected
//   response of the single transaction in flight.
// ----------------------------------------------------------------------------
module tb_fsm_engine_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int TIMEOUT    = 16;

  // Cycle offsets from the accept cycle for a conforming engine and for a
  // stuck engine
  localparam int RESP_OFF_OK    = 10;
  localparam int RELEASE_OFF    = 7;
  localparam int ABORT_OFF      = TIMEOUT + 2;
  localparam int RESP_OFF_ABORT = TIMEOUT + 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  fsm_engine_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  logic                  engEnable;
  logic [1:0]            engInputSignal;
  logic [DATA_WIDTH-1:0] engDataIn;
  logic [1:0]            engState;
  logic                  engBusy;
  logic                  engDone;
  logic                  engValid;
  logic [DATA_WIDTH-1:0] engDataOut;
  logic                  active;
  logic [7:0]            abortCount;

  fsm_engine_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .eng_enable      (engEnable),
    .eng_input_signal(engInputSignal),
    .eng_data_in     (engDataIn),
    .eng_state       (engState),
    .eng_busy        (engBusy),
    .eng_done        (engDone),
    .eng_valid       (engValid),
    .eng_data_out    (engDataOut),
    .active          (active),
    .abort_count     (abortCount)
  );

  // The engine's transform of an operand
  function automatic logic [7:0] engineResult(input logic [7:0] x);
    return x ^ 8'hCD;
  endfunction

  // Behavioural engine. IDLE takes start, four PROCESS cycles lead to WAIT,
  // release gives one quiet cycle, then one cycle with valid/done, then IDLE.
  // engStuck freezes PROCESS. Command 11 returns the engine to IDLE.
  logic [1:0] eState;
  int         eCnt;
  logic [7:0] eData;
  bit         engStuck;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eState <= 2'd0;
      eCnt   <= 0;
      eData  <= 8'h00;
    end else begin
      case (eState)
        2'd0: if (engEnable && engInputSignal == 2'b01) begin
          eData  <= engDataIn;
          eState <= 2'd1;
          eCnt   <= 0;
        end
        2'd1: if (engInputSignal == 2'b11) eState <= 2'd0;
              else if (!engStuck) begin
                if (eCnt == 3) eState <= 2'd2;
                else eCnt <= eCnt + 1;
              end
        2'd2: if (engInputSignal == 2'b10) begin
                eState <= 2'd3;
                eCnt   <= 0;
              end else if (engInputSignal == 2'b11) eState <= 2'd0;
        default: if (eCnt == 1) eState <= 2'd0;
                 else eCnt <= eCnt + 1;
      endcase
    end
  end

  assign engState   = eState;
  assign engBusy    = (eState != 2'd0);
  assign engValid   = (eState == 2'd3) && (eCnt == 1);
  assign engDone    = engValid;
  assign engDataOut = engValid ? engineResult(eData) : 8'h00;

  // Scoreboard counters and reference-model state
  int         nCompared   = 0;
  int         nMismatched = 0;
  int         cyc         = 0;
  int         nDone       = 0;
  bit         mBusy;
  bit         mStuck;
  int         mStart;
  int         mPtr;
  int         mId;
  int         mRespOff;
  logic [7:0] mData;
  logic [7:0] mExpData;
  logic       mExpErr;
  logic [7:0] mAbortCnt;
  bit         stuckArm;
  bit         randStuck;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs. mode: 0 none, 1 only req2 with 0x10,
  // 2 all requesters, 3 req1 and req3, 4 random subset
  task automatic applyStimulus(input int mode, input int readyPct);
    logic [NUM_REQ-1:0]            v;
    logic [NUM_REQ*DATA_WIDTH-1:0] d;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
    case (mode)
      1: begin v[2] = 1'b1; d[2*DATA_WIDTH +: DATA_WIDTH] = 8'h10; end
      2: v = '1;
      3: begin v[1] = 1'b1; v[3] = 1'b1; end
      4: v = NUM_REQ'($urandom);
      default: v = '0;
    endcase
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.resp_ready = ($urandom_range(99) < readyPct);
  endtask

  // Compare one cycle against the reference model, then advance the model
  task automatic checkCycle();
    int         expWin;
    int         idx;
    int         off;
    logic       expEn;
    logic [1:0] expSig;
    logic [7:0] expDin;
    if (!mBusy) begin
      expWin = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (mPtr + k) % NUM_REQ;
        if (expWin < 0 && bus.req_valid[idx]) expWin = idx;
      end
      checkOutput("req_ready", 32'(bus.req_ready), (expWin >= 0) ? (32'd1 << expWin) : 32'd0);
      checkOutput("active_idle", 32'(active), 32'd0);
      checkOutput("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
      checkOutput("eng_cmd_idle", 32'(engInputSignal), 32'd0);
      checkOutput("abort_count", 32'(abortCount), 32'(mAbortCnt));
      if (expWin >= 0) begin
        mBusy  = 1'b1;
        mStart = cyc;
        mId    = expWin;
        mPtr   = expWin;
        mData  = bus.req_data[expWin*DATA_WIDTH +: DATA_WIDTH];
        mStuck = stuckArm || (randStuck && $urandom_range(9) == 0);
        stuckArm = 1'b0;
        if (mStuck) begin
          engStuck  = 1'b1;
          mExpData  = 8'h00;
          mExpErr   = 1'b1;
          mRespOff  = RESP_OFF_ABORT;
          mAbortCnt = (mAbortCnt == 8'hFF) ? 8'hFF : mAbortCnt + 8'd1;
        end else begin
          mExpData = engineResult(mData);
          mExpErr  = 1'b0;
          mRespOff = RESP_OFF_OK;
        end
      end
    end else begin
      off    = cyc - mStart;
      expEn  = 1'b0;
      expSig = 2'b00;
      expDin = 8'h00;
      if (off == 1) begin
        expEn = 1'b1; expSig = 2'b01; expDin = mData;
      end else if (!mStuck && off == RELEASE_OFF) begin
        expEn = 1'b1; expSig = 2'b10;
      end else if (mStuck && off == ABORT_OFF) begin
        expEn = 1'b1; expSig = 2'b11;
      end
      checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
      checkOutput("active_busy", 32'(active), 32'd1);
      checkOutput("eng_enable", 32'(engEnable), 32'(expEn));
      checkOutput("eng_cmd", 32'(engInputSignal), 32'(expSig));
      checkOutput("eng_data_in", 32'(engDataIn), 32'(expDin));
      if (off < mRespOff) begin
        checkOutput("resp_valid_early", 32'(bus.resp_valid), 32'd0);
      end else begin
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("resp_id", 32'(bus.resp_id), 32'(mId));
        checkOutput("resp_data", 32'(bus.resp_data), 32'(mExpData));
        checkOutput("resp_error", 32'(bus.resp_error), 32'(mExpErr));
        checkOutput("abort_count_resp", 32'(abortCount), 32'(mAbortCnt));
        if (bus.resp_ready) begin
          mBusy    = 1'b0;
          engStuck = 1'b0;
          nDone++;
        end
      end
    end
  endtask

  task automatic runCycle(input int mode, input int readyPct);
    @(negedge clk);
    cyc++;
    applyStimulus(mode, readyPct);
    #1;
    checkCycle();
  endtask

  task automatic runPhase(input string tag, input int mode, input int readyPct,
                          input int nTxn, input int maxCycles);
    int base;
    int c;
    base = nDone;
    c    = 0;
    while ((nDone - base) < nTxn && c < maxCycles) begin
      runCycle(mode, readyPct);
      c++;
    end
    checkOutput(tag, 32'(nDone - base), 32'(nTxn));
  endtask

  // Asynchronous reset pulse, issued between clock edges. Outputs must
  // clear without waiting for a clock.
  task automatic doReset();
    #2;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    reset_n        = 1'b0;
    #1;
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_id", 32'(bus.resp_id), 32'd0);
    checkOutput("rst_resp_data", 32'(bus.resp_data), 32'd0);
    checkOutput("rst_resp_error", 32'(bus.resp_error), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_eng_enable", 32'(engEnable), 32'd0);
    checkOutput("rst_eng_cmd", 32'(engInputSignal), 32'd0);
    checkOutput("rst_eng_data_in", 32'(engDataIn), 32'd0);
    checkOutput("rst_abort_count", 32'(abortCount), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    mBusy     = 1'b0;
    mPtr      = NUM_REQ - 1;
    mAbortCnt = 8'h00;
    engStuck  = 1'b0;
    stuckArm  = 1'b0;
  endtask

  initial begin
    int c;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    engStuck       = 1'b0;
    randStuck      = 1'b0;
    stuckArm       = 1'b0;
    mBusy          = 1'b0;
    mPtr           = NUM_REQ - 1;
    mAbortCnt      = 8'h00;

    doReset();
    runPhase("single_req2", 1, 100, 1, 60);

    doReset();
    runPhase("all_valid_rr", 2, 100, 5, 200);
    runPhase("req1_req3", 3, 100, 3, 150);
    runPhase("resp_stall", 2, 20, 4, 600);

    stuckArm = 1'b1;
    runPhase("abort_then_ok", 2, 100, 2, 200);

    randStuck = 1'b1;
    runPhase("random_mix", 4, 60, 40, 4000);
    randStuck = 1'b0;

    c = 0;
    while (!(mBusy && (cyc - mStart) == 4) && c < 100) begin
      runCycle(2, 100);
      c++;
    end
    checkOutput("reach_run", 32'(mBusy && (cyc - mStart) == 4), 32'd1);
    doReset();
    runPhase("after_reset", 2, 100, 1, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
